lzss_stream_arb: RTL

LZSS_STREAM_ARB -- requirements
Module: lzss_stream_arb

---
 rtl/lzss_stream_arb_pkg.sv | 20 ++
 rtl/lzss_stream_arb_rr_pick.sv | 14 +
 rtl/lzss_stream_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lzss_stream_arb_pkg.sv
// Shared types and widths for the LZSS stream arbiter.
// FSM state codes live here so the top and any tooling agree.
package lzss_stream_arb_pkg;

  localparam int DATA_W = 32;
  localparam int CW_W   = 11;
  localparam int NUM_W  = 12;

  localparam logic [NUM_W-1:0] WDOG_MAX = 12'd4095;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RESTART = 3'd1;
  localparam state_t S_WAIT    = 3'd2;
  localparam state_t S_FEED    = 3'd3;
  localparam state_t S_DRAIN   = 3'd4;
  localparam state_t S_REPORT  = 3'd5;

endpackage

// File: rtl/lzss_stream_arb_rr_pick.sv
// Two-way round-robin grant: on a tie the requester
// not served last wins, otherwise the lone requester.
module lzss_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic any,
  output logic grant
);

  assign any   = valid0 | valid1;
  assign grant = (valid0 & valid1) ? ~last : valid1;

endmodule

// File: rtl/lzss_stream_arb.sv
// Arbitrates two word streams onto one LZSS encoder and
// routes codewords and a completion report to the owner.
module lzss_stream_arb
  import lzss_stream_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_valid,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_valid,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              enc_restart,
  output logic [DATA_W-1:0] enc_data,
  output logic              enc_data_valid,
  output logic              enc_drop_done,
  input  logic              enc_busy,
  input  logic              enc_out_valid,
  input  logic              enc_finish,
  input  logic [CW_W-1:0]   enc_codeword,
  input  logic [NUM_W-1:0]  enc_enc_num,
  output logic [CW_W-1:0]   cw_data,
  output logic              cw_valid,
  output logic              cw_id,
  output logic              done,
  output logic              done_id,
  output logic [NUM_W-1:0]  done_count,
  output logic              done_err
);

  state_t state;
  logic owner;
  logic rr_last;
  logic holdoff;
  logic wd_fired;
  logic [NUM_W-1:0] cw_cnt;
  logic [NUM_W-1:0] wdog;
  logic [NUM_W-1:0] num_q;
  logic [15:0] word_cnt;
  logic [CW_W-1:0] cw_data_q;
  logic cw_valid_q;
  logic cw_id_q;
  logic pick_any;
  logic pick_id;
  logic own_valid;
  logic own_last;
  logic [DATA_W-1:0] own_data;
  logic in_feed;
  logic in_drain;
  logic in_report;
  logic dvalid;
  logic xfer;
  logic cw_take;

  lzss_rr_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (rr_last),
    .any    (pick_any),
    .grant  (pick_id)
  );

  assign own_valid = owner ? req1_valid : req0_valid;
  assign own_last  = owner ? req1_last  : req0_last;
  assign own_data  = owner ? req1_data  : req0_data;

  assign in_feed   = state == S_FEED;
  assign in_drain  = state == S_DRAIN;
  assign in_report = state == S_REPORT;

  assign dvalid  = in_feed & own_valid & ~holdoff;
  assign xfer    = dvalid & ~enc_busy;
  assign cw_take = (in_feed | in_drain) & enc_out_valid;

  // Stream sequencing, spacing holdoff and drain watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      holdoff  <= 1'b0;
      wd_fired <= 1'b0;
      wdog     <= '0;
      num_q    <= '0;
      word_cnt <= '0;
    end else begin
      holdoff <= xfer;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            owner <= pick_id;
            state <= S_RESTART;
          end
        end
        S_RESTART: begin
          wdog     <= '0;
          wd_fired <= 1'b0;
          word_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: state <= S_FEED;
        S_FEED: begin
          if (xfer) begin
            word_cnt <= word_cnt + 16'd1;
            if (own_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (enc_finish) begin
            num_q <= enc_enc_num;
            state <= S_REPORT;
          end else if (wdog == WDOG_MAX - 12'd1) begin
            wd_fired <= 1'b1;
            state    <= S_REPORT;
          end else begin
            wdog <= wdog + 12'd1;
          end
        end
        S_REPORT: begin
          rr_last <= owner;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Codeword return path, one cycle behind the encoder
  always_ff @(posedge clk) begin
    if (reset) begin
      cw_data_q  <= '0;
      cw_valid_q <= 1'b0;
      cw_id_q    <= 1'b0;
      cw_cnt     <= '0;
    end else begin
      cw_valid_q <= cw_take;
      if (cw_take) begin
        cw_data_q <= enc_codeword;
        cw_id_q   <= owner;
        if (cw_cnt != '1) cw_cnt <= cw_cnt + 12'd1;
      end
      if (state == S_RESTART) cw_cnt <= '0;
    end
  end

  // Output decode; reset forces the quiet/restart pattern
  always_comb begin
    enc_restart    = reset | (state == S_RESTART);
    enc_data       = in_feed ? own_data : '0;
    enc_data_valid = dvalid;
    enc_drop_done  = in_drain;
    req0_ready     = xfer & ~owner;
    req1_ready     = xfer & owner;
    cw_data        = cw_data_q;
    cw_valid       = cw_valid_q;
    cw_id          = cw_id_q;
    done           = in_report;
    done_id        = in_report & owner;
    done_count     = '0;
    if (in_report) done_count = wd_fired ? cw_cnt : num_q;
    done_err       = in_report & (wd_fired | (cw_cnt != num_q));
    if (reset) begin
      enc_data       = '0;
      enc_data_valid = 1'b0;
      enc_drop_done  = 1'b0;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      cw_data        = '0;
      cw_valid       = 1'b0;
      cw_id          = 1'b0;
      done           = 1'b0;
      done_id        = 1'b0;
      done_count     = '0;
      done_err       = 1'b0;
    end
  end

endmodule
